march_program_sequencer: RTL and testbench

MARCH_PROGRAM_SEQUENCER -- requirements
Module: march_program_sequencer

---
 rtl/march_program_sequencer.sv | 130 +++++++++++++
 tb/tb_march_program_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/march_program_sequencer.sv
// Steps a BIST engine through a stored list of march elements, one scan word per
// element, and collects the run verdict, miscompare count and first-failure location.
module march_program_sequencer #(
    parameter int SW           = 16,
    parameter int AW           = 8,
    parameter int PW           = 4,
    parameter int TW           = 16,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [PW-1:0] prog_addr,
    input  logic [SW-1:0] prog_wdata,
    input  logic [PW-1:0] prog_last,
    input  logic          start,
    input  logic          elem_done_in,
    input  logic          fail_in,
    input  logic [AW-1:0] tas_in,
    output logic [SW-1:0] scan_out,
    output logic          ts_out,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [7:0]    fail_cnt,
    output logic [AW-1:0] first_fail_addr,
    output logic [PW-1:0] first_fail_elem,
    output logic [PW-1:0] cur_elem
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t        state;
    logic [SW-1:0] prog [2**PW];
    logic [PW-1:0] last;
    logic [TW-1:0] wd;

    logic          fail_hit;
    logic          stop_hit;
    logic          adv;
    logic          to_hit;
    logic          end_run;
    logic [7:0]    fail_cnt_nxt;
    logic [PW-1:0] nxt_elem;

    always_comb begin
        fail_hit     = (state == RUN) && fail_in;
        stop_hit     = STOP_ON_FAIL && fail_hit;
        adv          = (state == RUN) && elem_done_in && !stop_hit;
        to_hit       = (state == RUN) && !elem_done_in && !stop_hit &&
                       ((wd + TW'(1)) == {TW{1'b1}});
        end_run      = stop_hit || to_hit || (adv && (cur_elem == last));
        nxt_elem     = cur_elem + PW'(1);
        fail_cnt_nxt = fail_cnt;
        if (fail_hit && (fail_cnt != 8'hFF))
            fail_cnt_nxt = fail_cnt + 8'd1;
    end

    // Program store survives reset so a run can be repeated after an abort.
    always_ff @(posedge clk) begin
        if (prog_we && !busy)
            prog[prog_addr] <= prog_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            last            <= '0;
            wd              <= '0;
            scan_out        <= '0;
            ts_out          <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            timeout         <= 1'b0;
            fail_cnt        <= '0;
            first_fail_addr <= '0;
            first_fail_elem <= '0;
            cur_elem        <= '0;
        end else begin
            ts_out <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    // scan_out is loaded on the edge into LOAD so it is valid with ts_out
                    last            <= prog_last;
                    cur_elem        <= '0;
                    fail_cnt        <= '0;
                    first_fail_addr <= '0;
                    first_fail_elem <= '0;
                    timeout         <= 1'b0;
                    pass            <= 1'b0;
                    scan_out        <= prog[0];
                    ts_out          <= 1'b1;
                    busy            <= 1'b1;
                    wd              <= '0;
                    state           <= LOAD;
                end
                LOAD: begin
                    wd    <= '0;
                    state <= RUN;
                end
                RUN: begin
                    wd       <= wd + TW'(1);
                    fail_cnt <= fail_cnt_nxt;
                    // Capture uses the pre-advance element index.
                    if (fail_hit && (fail_cnt == 8'd0)) begin
                        first_fail_addr <= tas_in;
                        first_fail_elem <= cur_elem;
                    end
                    if (end_run) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= to_hit;
                        pass    <= (fail_cnt_nxt == 8'd0) && !to_hit;
                    end else if (adv) begin
                        cur_elem <= nxt_elem;
                        scan_out <= prog[nxt_elem];
                        ts_out   <= 1'b1;
                        state    <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_march_program_sequencer.sv
// Directed bench: three sequencer instances (default, stop-on-fail, 4-bit watchdog)
// share one stimulus; each test checks the instance it targets.
module tb_march_program_sequencer;

    localparam int SW = 16;
    localparam int AW = 8;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          prog_we = 1'b0;
    logic [PW-1:0] prog_addr = '0;
    logic [SW-1:0] prog_wdata = '0;
    logic [PW-1:0] prog_last = '0;
    logic          start = 1'b0;
    logic          elem_done_in = 1'b0;
    logic          fail_in = 1'b0;
    logic [AW-1:0] tas_in = '0;

    logic [2:0]    ts_w, busy_w, done_w, pass_w, to_w;
    logic [SW-1:0] scan_w  [3];
    logic [7:0]    cnt_w   [3];
    logic [AW-1:0] faddr_w [3];
    logic [PW-1:0] felem_w [3];
    logic [PW-1:0] cur_w   [3];

    int n_chk = 0;
    int n_pass = 0;

    logic [SW-1:0] words [3];

    int            nts, ndone, done_k, done_cyc, fail_cyc, first_ts_c;
    logic [SW-1:0] scans [4];
    logic          d_pass, d_to;
    logic [7:0]    d_cnt;
    logic [AW-1:0] d_addr;
    logic [PW-1:0] d_elem, d_cur;

    always #5 clk = ~clk;

    march_program_sequencer #(.SW(SW), .AW(AW), .PW(PW), .TW(16), .STOP_ON_FAIL(1'b0)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .prog_last(prog_last), .start(start), .elem_done_in(elem_done_in), .fail_in(fail_in),
        .tas_in(tas_in), .scan_out(scan_w[0]), .ts_out(ts_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .pass(pass_w[0]), .timeout(to_w[0]), .fail_cnt(cnt_w[0]), .first_fail_addr(faddr_w[0]),
        .first_fail_elem(felem_w[0]), .cur_elem(cur_w[0]));

    march_program_sequencer #(.SW(SW), .AW(AW), .PW(PW), .TW(16), .STOP_ON_FAIL(1'b1)) dut_s (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .prog_last(prog_last), .start(start), .elem_done_in(elem_done_in), .fail_in(fail_in),
        .tas_in(tas_in), .scan_out(scan_w[1]), .ts_out(ts_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .pass(pass_w[1]), .timeout(to_w[1]), .fail_cnt(cnt_w[1]), .first_fail_addr(faddr_w[1]),
        .first_fail_elem(felem_w[1]), .cur_elem(cur_w[1]));

    march_program_sequencer #(.SW(SW), .AW(AW), .PW(PW), .TW(4), .STOP_ON_FAIL(1'b0)) dut_t (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .prog_last(prog_last), .start(start), .elem_done_in(elem_done_in), .fail_in(fail_in),
        .tas_in(tas_in), .scan_out(scan_w[2]), .ts_out(ts_w[2]), .busy(busy_w[2]), .done(done_w[2]),
        .pass(pass_w[2]), .timeout(to_w[2]), .fail_cnt(cnt_w[2]), .first_fail_addr(faddr_w[2]),
        .first_fail_elem(felem_w[2]), .cur_elem(cur_w[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag, input int s);
        chk({tag, "_scan"},  32'(scan_w[s]), 0);
        chk({tag, "_ts"},    32'(ts_w[s]), 0);
        chk({tag, "_busy"},  32'(busy_w[s]), 0);
        chk({tag, "_done"},  32'(done_w[s]), 0);
        chk({tag, "_pass"},  32'(pass_w[s]), 0);
        chk({tag, "_to"},    32'(to_w[s]), 0);
        chk({tag, "_cnt"},   32'(cnt_w[s]), 0);
        chk({tag, "_faddr"}, 32'(faddr_w[s]), 0);
        chk({tag, "_felem"}, 32'(felem_w[s]), 0);
        chk({tag, "_cur"},   32'(cur_w[s]), 0);
    endtask

    // Start a run on instance s; elem_done 5 cycles after each ts_out unless no_edone.
    // Fails are injected k cycles after the ts_out of elements fe0 / fe1 (-1 = none).
    task automatic run(input int s, input logic [PW-1:0] lst, input int fe0, input int fk0,
                       input int fe1, input int fk1, input bit no_edone);
        int k, post;
        bit f;
        pulse_rst();
        prog_last = lst;
        start = 1'b1;
        step();
        start = 1'b0;
        nts = 0; ndone = 0; k = 0; post = -1;
        done_k = -1; done_cyc = -1; fail_cyc = -1; first_ts_c = -1;
        for (int c = 0; c < 200; c++) begin
            if (ts_w[s]) begin
                if (nts < 4) scans[nts] = scan_w[s];
                if (first_ts_c < 0) first_ts_c = c;
                nts++;
                k = 0;
            end else k++;
            if (done_w[s]) begin
                ndone++;
                done_k = k; done_cyc = c;
                d_pass = pass_w[s]; d_to = to_w[s]; d_cnt = cnt_w[s];
                d_addr = faddr_w[s]; d_elem = felem_w[s]; d_cur = cur_w[s];
                if (post < 0) post = 3;
            end
            f = (post < 0) && (((nts == fe0 + 1) && (k == fk0)) || ((nts == fe1 + 1) && (k == fk1)));
            fail_in = f;
            tas_in = f ? ((nts == fe0 + 1) ? 8'h2A : 8'h55) : 8'h00;
            if (f) fail_cyc = c;
            elem_done_in = !no_edone && (k == 5) && (post < 0);
            step();
            if (post > 0) post--;
            if (post == 0) break;
        end
        fail_in = 1'b0;
        elem_done_in = 1'b0;
        tas_in = '0;
        chk("run_finished", 32'(post == 0), 1);
    endtask

    initial begin
        words[0] = 16'hA5A5;
        words[1] = 16'h3C3C;
        words[2] = 16'h0F0F;

        rst = 1'b1;
        step();
        step();
        chk_zero("reset", 0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            prog_we = 1'b1;
            prog_addr = PW'(i);
            prog_wdata = words[i];
            step();
        end
        prog_we = 1'b0;

        // Clean three-element run
        run(0, 2, -1, 0, -1, 0, 1'b0);
        chk("clean_first_ts", 32'(first_ts_c), 0);
        chk("clean_nts", 32'(nts), 3);
        for (int i = 0; i < 3; i++) chk("clean_scan", 32'(scans[i]), 32'(words[i]));
        chk("clean_ndone", 32'(ndone), 1);
        chk("clean_pass", 32'(d_pass), 1);
        chk("clean_cnt", 32'(d_cnt), 0);
        chk("clean_pass_hold", 32'(pass_w[0]), 1);
        chk("clean_idle", 32'(busy_w[0]), 0);

        // Fails in element 1 (0x2A) and element 2 (0x55)
        run(0, 2, 1, 2, 2, 3, 1'b0);
        chk("fail_nts", 32'(nts), 3);
        chk("fail_cnt", 32'(d_cnt), 2);
        chk("fail_addr", 32'(d_addr), 32'h2A);
        chk("fail_elem", 32'(d_elem), 1);
        chk("fail_pass", 32'(d_pass), 0);
        chk("fail_cnt_hold", 32'(cnt_w[0]), 2);

        // Stop-on-fail instance: fail in element 0
        run(1, 2, 0, 2, -1, 0, 1'b0);
        chk("stop_latency", 32'(done_cyc - fail_cyc), 1);
        chk("stop_cur", 32'(d_cur), 0);
        chk("stop_nts", 32'(nts), 1);
        chk("stop_cnt", 32'(d_cnt), 1);
        chk("stop_pass", 32'(d_pass), 0);

        // 4-bit watchdog: 15 RUN cycles then DONE
        run(2, 2, -1, 0, -1, 0, 1'b1);
        chk("to_flag", 32'(d_to), 1);
        chk("to_done_k", 32'(done_k), 16);
        chk("to_pass", 32'(d_pass), 0);
        chk("to_ndone", 32'(ndone), 1);

        // Reset in the middle of a run
        pulse_rst();
        prog_last = 2;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        fail_in = 1'b1;
        tas_in = 8'h2A;
        step();
        fail_in = 1'b0;
        tas_in = '0;
        chk("mid_busy", 32'(busy_w[0]), 1);
        chk("mid_cnt", 32'(cnt_w[0]), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_zero("midrst", 0);
        run(0, 2, -1, 0, -1, 0, 1'b0);
        chk("rerun_nts", 32'(nts), 3);
        for (int i = 0; i < 3; i++) chk("rerun_scan", 32'(scans[i]), 32'(words[i]));
        chk("rerun_pass", 32'(d_pass), 1);

        // Write and start while busy are dropped; 300 fails saturate
        pulse_rst();
        prog_last = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        prog_we = 1'b1;
        prog_addr = 0;
        prog_wdata = 16'hFFFF;
        prog_last = 2;
        start = 1'b1;
        step();
        prog_we = 1'b0;
        start = 1'b0;
        fail_in = 1'b1;
        repeat (300) step();
        fail_in = 1'b0;
        elem_done_in = 1'b1;
        step();
        elem_done_in = 1'b0;
        chk("sat_done", 32'(done_w[0]), 1);
        chk("sat_cnt", 32'(cnt_w[0]), 255);
        chk("sat_cur", 32'(cur_w[0]), 0);
        chk("sat_pass", 32'(pass_w[0]), 0);
        step();
        chk("sat_done_pulse", 32'(done_w[0]), 0);
        chk("sat_idle", 32'(busy_w[0]), 0);
        run(0, 2, -1, 0, -1, 0, 1'b0);
        chk("busywr_scan0", 32'(scans[0]), 32'(words[0]));
        chk("busywr_nts", 32'(nts), 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
